// File: rtl/mdu_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module mdu_div_seq #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_op,
    input  logic [DataWidth-1:0] i_a,
    input  logic [DataWidth-1:0] i_b,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DataWidth-1:0] o_res,
    output logic                 o_busy
);

    localparam int unsigned CntWidth = $clog2(DataWidth + 1);
    localparam logic [DataWidth-1:0] MinNeg = {1'b1, {(DataWidth - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [DataWidth-1:0] quo_q, quo_d;
    logic [DataWidth-1:0] rem_q, rem_d;
    logic [DataWidth-1:0] dvs_q, dvs_d;
    logic                 op_rem_q, op_rem_d;
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] res_q, res_d;

    logic                 is_signed, a_neg, b_neg, div_zero, overflow, accept;
    logic [DataWidth-1:0] a_mag, b_mag;
    logic [DataWidth:0]   shifted, diff;
    logic                 trial_ok;
    logic [DataWidth-1:0] rem_new, quo_new, quo_fix, rem_fix;

    // Request decode: only DIV/REM (op[0]==0) are signed
    assign is_signed = ~i_op[0];
    assign a_neg     = is_signed & i_a[DataWidth-1];
    assign b_neg     = is_signed & i_b[DataWidth-1];
    assign a_mag     = a_neg ? -i_a : i_a;
    assign b_mag     = b_neg ? -i_b : i_b;
    assign div_zero  = (i_b == '0);
    assign overflow  = is_signed & (i_a == MinNeg) & (i_b == '1);
    assign accept    = i_valid & (state_q == IDLE) & ~i_flush;

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_valid = valid_q;
    assign o_res   = res_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        op_rem_d  = op_rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        valid_d   = valid_q;
        res_d     = res_q;

        // Shift in the next dividend bit and trial-subtract the divisor
        shifted  = {rem_q, quo_q[DataWidth-1]};
        diff     = shifted - {1'b0, dvs_q};
        trial_ok = (shifted >= {1'b0, dvs_q});
        rem_new  = DataWidth'(trial_ok ? diff : shifted);
        quo_new  = {quo_q[DataWidth-2:0], trial_ok};
        quo_fix  = quo_neg_q ? -quo_new : quo_new;
        rem_fix  = rem_neg_q ? -rem_new : rem_new;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_rem_d  = i_op[1];
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    if (div_zero) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        res_d   = i_op[1] ? i_a : '1;
                    end else if (overflow) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        res_d   = i_op[1] ? '0 : i_a;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CntWidth'(DataWidth);
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                    end
                end
            end
            CALC: begin
                quo_d = quo_new;
                rem_d = rem_new;
                cnt_d = cnt_q - CntWidth'(1);
                if (cnt_q == CntWidth'(1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    res_d   = op_rem_q ? rem_fix : quo_fix;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over acceptance and handoff; the last result stays on o_res
        if (i_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            op_rem_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            op_rem_q  <= op_rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq: directed corner cases plus random ops
// compared against a plain-arithmetic RV32M divide model.
module tb_mdu_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_res;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_exp = '0;

    mdu_div_seq #(.DataWidth(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V divide semantics from plain signed/unsigned arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one op, scramble inputs after acceptance, hold off i_ready, then hand off
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] exp;
        int n;
        exp = ref_div(op, a, b);
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
        check("ready_idle", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), is_special(op, a, b) ? 32'd0 : 32'd32);
        check("ready_busy", 32'(o_ready), 32'd0);
        check("result", o_res, exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_res", o_res, exp);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("handoff_valid", 32'(o_valid), 32'd0);
        check("handoff_ready", 32'(o_ready), 32'd1);
        last_exp = exp;
    endtask

    initial begin
        int n;
        bit seen_valid;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        i_flush = 1'b0; i_ready = 1'b0;
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_res", o_res, 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2", last_exp, 32'hFFFF_FFFD);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1);
        check("rem_m7_2", last_exp, 32'hFFFF_FFFF);
        do_op(2'b01, 32'd100, 32'd7, 0);
        do_op(2'b11, 32'd100, 32'd7, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(2'b00, 32'd5, 32'd0, 2);
        do_op(2'b11, 32'd5, 32'd0, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);

        // Backpressure with the next request already waiting
        @(negedge clk);
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd100; i_b = 32'd7;
        @(posedge clk); #1;
        i_a = 32'd50; i_b = 32'd5;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", 32'(n), 32'd32);
        check("bp_res", o_res, 32'd14);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_res", o_res, 32'd14);
            check("bp_hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("bp_handoff_valid", 32'(o_valid), 32'd0);
        check("bp_not_accepted", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("bp_accepted", 32'(o_busy), 32'd1);
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_second_res", o_res, 32'd10);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        last_exp = 32'd10;

        // Flush in the middle of an iteration
        @(negedge clk);
        i_valid = 1'b1; i_op = 2'b01; i_a = 32'd1000; i_b = 32'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush_ready", 32'(o_ready), 32'd1);
        check("flush_busy", 32'(o_busy), 32'd0);
        check("flush_res_kept", o_res, last_exp);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) seen_valid = 1'b1;
        end
        check("flush_no_valid", 32'(seen_valid), 32'd0);
        do_op(2'b00, 32'd9, 32'd3, 0);
        check("after_flush", last_exp, 32'd3);

        // Asynchronous reset mid-iteration
        @(negedge clk);
        i_valid = 1'b1; i_op = 2'b00; i_a = 32'hFFFF_FC18; i_b = 32'd7;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_res", o_res, 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b00, 32'hFFFF_FC18, 32'd7, 0);

        // Random ops with biased corner operands
        for (int t = 0; t < 40; t++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
